// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits, and per-word parity/framing/break plus sticky overrun.
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [15:0]          baud_div,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  input  logic                 ack
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP1 = 3'd4,
    STOP2 = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(DATA_BITS - 1);

  state_t               state;
  state_t               state_nxt;
  logic                 rx_meta;
  logic [2:0]           rx_hist;
  logic                 rx_s;
  logic [15:0]          cnt;
  logic [15:0]          reload_div;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_err_w;
  logic                 frame_err_w;
  logic                 sample;
  logic                 vote;
  logic                 start_edge;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 done;
  logic                 frame_err_new;
  logic                 break_new;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Expected parity bit: even sets it to the XOR of the data, odd to its inverse.
  function automatic logic exp_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  // rx_hist[0] is rx_s; [1] and [2] are the two previous rx_s values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_hist <= 3'b111;
    end else begin
      rx_meta <= rx;
      rx_hist <= {rx_hist[1:0], rx_meta};
    end
  end

  assign rx_s   = rx_hist[0];
  assign vote   = maj3(rx_hist);
  assign sample = (state != IDLE) && (cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (sample) state_nxt = vote ? IDLE : DATA;
      DATA:  if (sample && (bit_idx == LAST_IDX)) state_nxt = (PARITY != 0) ? PAR : STOP1;
      PAR:   if (sample) state_nxt = STOP1;
      STOP1: if (sample) state_nxt = (STOP_BITS == 2) ? STOP2 : IDLE;
      STOP2: if (sample) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_edge = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  start_edge = !rx_s && rx_hist[1];
      DATA:  shift_en = sample;
      PAR:   par_en = sample;
      STOP1: begin
        stop_en = sample;
        done    = sample && (STOP_BITS != 2);
      end
      STOP2: begin
        stop_en = sample;
        done    = sample;
      end
      default: ;
    endcase
  end

  // Bit timing and frame assembly; the reload value is frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 16'd0;
      reload_div  <= 16'd0;
      bit_idx     <= 4'd0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      par_err_w   <= 1'b0;
      frame_err_w <= 1'b0;
    end else begin
      if (start_edge) begin
        cnt         <= baud_div >> 1;
        reload_div  <= baud_div;
        bit_idx     <= 4'd0;
        par_bit     <= 1'b0;
        par_err_w   <= 1'b0;
        frame_err_w <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= (cnt == 16'd0) ? reload_div : cnt - 16'd1;
      end
      if (shift_en) begin
        shreg   <= {vote, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 4'd1;
      end
      if (par_en) begin
        par_bit   <= vote;
        par_err_w <= (vote != exp_par(shreg));
      end
      if (stop_en && !vote) frame_err_w <= 1'b1;
    end
  end

  assign frame_err_new = frame_err_w | !vote;
  assign break_new     = (shreg == '0) && ((PARITY == 0) || !par_bit) && frame_err_new;

  // Completion either delivers the word (slot free or being freed by ack) or drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done && (!valid || ack)) begin
      valid      <= 1'b1;
      data_out   <= shreg;
      parity_err <= (PARITY != 0) && par_err_w;
      frame_err  <= frame_err_new;
      break_det  <= break_new;
      if (valid) overrun <= 1'b0;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (valid && ack) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
